// File: rtl/aes_pkg.sv
// Shared constants and FSM state type for the iterative AES-128 round sequencer.
package aes_pkg;

   localparam int unsigned AES_BLK_W = 128;
   localparam int unsigned AES128_NR = 10;
   localparam int unsigned AES_RND_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } aes_fsm_e;

endpackage : aes_pkg

// File: rtl/aes_round_cnt.sv
// Round index counter: clear, load-to-1, saturating increment, terminal-count flag.
module aes_round_cnt
   import aes_pkg::*;
#(
   parameter int unsigned NR = AES128_NR,
   parameter int unsigned RW = AES_RND_W
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr_i,
   input  logic          load_i,
   input  logic          inc_i,
   output logic [RW-1:0] cnt_o,
   output logic          tc_o
);

   logic [RW-1:0] cnt_q;
   logic [RW-1:0] cnt_d;

   // Terminal count: the final round; the count never moves past it.
   assign tc_o  = (cnt_q == RW'(NR));
   assign cnt_o = cnt_q;

   // Next count: clear wins over load, load wins over increment.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         cnt_d = RW'(1);
      end else if (inc_i && !tc_o) begin
         cnt_d = cnt_q + RW'(1);
      end
   end

   // Count register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule : aes_round_cnt

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 round sequencer: drives the upstream 2:1 select and owns the state register.
module aes_round_ctrl
   import aes_pkg::*;
#(
   parameter int unsigned NR = AES128_NR,
   parameter int unsigned DW = AES_BLK_W,
   parameter int unsigned RW = AES_RND_W
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   output logic          mux_sel,
   input  logic [DW-1:0] mux_out,
   output logic [DW-1:0] state_q,
   output logic [RW-1:0] round_idx,
   output logic          last_round,
   output logic          busy,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] data_out
);

   aes_fsm_e fsm_q;
   logic     fsm_bad;
   logic     cnt_clr;
   logic     cnt_load;
   logic     cnt_inc;
   logic     cnt_tc;

   // Handshake and select outputs decode the state register alone.
   assign in_ready  = (fsm_q == IDLE);
   assign mux_sel   = (fsm_q == IDLE);
   assign busy      = (fsm_q == RUN);
   assign out_valid = (fsm_q == DONE);
   assign data_out  = state_q;
   assign fsm_bad   = (fsm_q != IDLE) && (fsm_q != RUN) && (fsm_q != DONE);

   // Round index control: load on accept, step in RUN, clear on output handshake.
   assign cnt_load = (fsm_q == IDLE) && in_valid;
   assign cnt_inc  = (fsm_q == RUN);
   assign cnt_clr  = ((fsm_q == DONE) && out_ready) || fsm_bad;

   aes_round_cnt #(
      .NR (NR),
      .RW (RW)
   ) u_round_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (cnt_clr),
      .load_i (cnt_load),
      .inc_i  (cnt_inc),
      .cnt_o  (round_idx),
      .tc_o   (cnt_tc)
   );

   assign last_round = cnt_tc;

   // Sequencer FSM and AES state register; reset aborts any block in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fsm_q   <= IDLE;
         state_q <= '0;
      end else begin
         case (fsm_q)
            IDLE: begin
               if (in_valid) begin
                  state_q <= mux_out;
                  fsm_q   <= RUN;
               end
            end
            RUN: begin
               state_q <= mux_out;
               if (cnt_tc) begin
                  fsm_q <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  fsm_q <= IDLE;
               end
            end
            default: begin
               fsm_q <= IDLE;
            end
         endcase
      end
   end

endmodule : aes_round_ctrl

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl with stub and real AES round logic around it.
module tb_aes_round_ctrl;
   import aes_pkg::*;

   localparam int unsigned DW = 128;
   localparam int unsigned RW = 4;

   logic          clk;
   logic          rst_n;
   logic          in_valid, in_ready, mux_sel, last_round, busy, out_valid, out_ready;
   logic [DW-1:0] mux_out, state_q, data_out;
   logic [RW-1:0] round_idx;

   logic          in_valid_b, in_ready_b, mux_sel_b, last_round_b, busy_b, out_valid_b, out_ready_b;
   logic [DW-1:0] mux_out_b, state_q_b, data_out_b;
   logic [RW-1:0] round_idx_b;

   logic [DW-1:0] data_in, data_in_b, fb;
   logic          real_mode;
   logic [7:0]    sbox [256];
   logic [127:0]  rk_cur [0:15];

   int errors;
   int checks;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   aes_round_ctrl #(.NR(10), .DW(DW), .RW(RW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .mux_sel(mux_sel),
      .mux_out(mux_out), .state_q(state_q), .round_idx(round_idx), .last_round(last_round),
      .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out)
   );

   aes_round_ctrl #(.NR(12), .DW(DW), .RW(RW)) dut12 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b), .mux_sel(mux_sel_b),
      .mux_out(mux_out_b), .state_q(state_q_b), .round_idx(round_idx_b), .last_round(last_round_b),
      .busy(busy_b), .out_valid(out_valid_b), .out_ready(out_ready_b), .data_out(data_out_b)
   );

   // ---------------- AES reference arithmetic ----------------
   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa, bb;
      p = 8'h00; aa = a; bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = xt(aa);
         bb = bb >> 1;
      end
      return p;
   endfunction

   task automatic init_sbox();
      logic [7:0] inv, s;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
         sbox[x] = s;
      end
   endtask

   function automatic logic [7:0] getb(input logic [127:0] s, input int i);
      return s[127-8*i -: 8];
   endfunction

   // State byte (row r, column c) sits at byte index r + 4c, byte 0 being the MSB.
   function automatic logic [127:0] sub_shift(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            o[127-8*(r+4*c) -: 8] = sbox[getb(s, r + 4*((c+r)%4))];
      return o;
   endfunction

   function automatic logic [127:0] mix_cols(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = getb(s, 4*c); a1 = getb(s, 4*c+1); a2 = getb(s, 4*c+2); a3 = getb(s, 4*c+3);
         o[127-8*(4*c)   -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
         o[127-8*(4*c+1) -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
         o[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
         o[127-8*(4*c+3) -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
      return o;
   endfunction

   function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                              input logic last);
      logic [127:0] ss;
      ss = sub_shift(s);
      return (last ? ss : mix_cols(ss)) ^ k;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
   endfunction

   function automatic logic [127:0] round_key(input logic [127:0] key, input int n);
      logic [31:0] w [0:59];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 4*n+4; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
   endfunction

   function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [127:0] key);
      logic [127:0] s;
      s = pt ^ round_key(key, 0);
      for (int r = 1; r <= 10; r++) s = aes_round(s, round_key(key, r), r == 10);
      return s;
   endfunction

   // ---------------- external round logic and select stage ----------------
   always_comb begin
      fb = state_q + 128'd1;
      if (real_mode) fb = aes_round(state_q, rk_cur[round_idx], last_round);
   end
   assign mux_out   = mux_sel ? (real_mode ? (data_in ^ rk_cur[0]) : data_in) : fb;
   assign mux_out_b = mux_sel_b ? data_in_b : (state_q_b + 128'd1);

   // ---------------- stimulus helpers ----------------
   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_key(input logic [127:0] key);
      for (int n = 0; n <= 10; n++) rk_cur[n] = round_key(key, n);
   endtask

   task automatic accept(input logic [127:0] d);
      data_in  = d;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   // n counts edges starting with the accepting edge as 1.
   task automatic wait_done(output int n);
      n = 1;
      while (out_valid !== 1'b1 && n < 60) begin
         tick();
         n++;
      end
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_valid_b = 1'b0; out_ready_b = 1'b0;
      real_mode = 1'b0; data_in = '0; data_in_b = '0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      checks++; if ({in_ready, mux_sel, busy, out_valid, last_round} !== 5'b11000) begin
         errors++; $display("FAIL reset_flags: got %b want 11000", {in_ready, mux_sel, busy, out_valid, last_round});
      end
      checks++; if (state_q !== 128'd0) begin
         errors++; $display("FAIL reset_state: got %h want 0", state_q);
      end
      checks++; if (round_idx !== 4'd0) begin
         errors++; $display("FAIL reset_round: got %0d want 0", round_idx);
      end
      checks++; if ({in_ready_b, busy_b, out_valid_b} !== 3'b100) begin
         errors++; $display("FAIL reset_nr12: got %b want 100", {in_ready_b, busy_b, out_valid_b});
      end
   endtask

   task automatic test_stub_latency();
      int n;
      logic [127:0] d;
      real_mode = 1'b0;
      for (int blk = 0; blk < 2; blk++) begin
         d = (blk == 0) ? 128'd0 : rand128();
         accept(d);
         n = 1;
         while (out_valid !== 1'b1 && n < 60) begin
            checks++; if (round_idx !== 4'(n) || last_round !== (n == 10) || busy !== 1'b1) begin
               errors++; $display("FAIL stub_round_seq: step %0d got idx=%0d last=%b busy=%b", n, round_idx, last_round, busy);
            end
            tick();
            n++;
         end
         checks++; if (n != 11) begin
            errors++; $display("FAIL stub_latency: got %0d want 11", n);
         end
         checks++; if (data_out !== d + 128'd10) begin
            errors++; $display("FAIL stub_data: got %h want %h", data_out, d + 128'd10);
         end
         checks++; if ({in_ready, mux_sel, busy, last_round} !== 4'b0001 || round_idx !== 4'd10) begin
            errors++; $display("FAIL stub_done_flags: got %b idx=%0d", {in_ready, mux_sel, busy, last_round}, round_idx);
         end
         release_out();
         checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || round_idx !== 4'd0) begin
            errors++; $display("FAIL stub_release: got rdy=%b ov=%b idx=%0d", in_ready, out_valid, round_idx);
         end
      end
   endtask

   task automatic test_fips();
      int n;
      logic [127:0] pt, key, exp;
      real_mode = 1'b1;
      set_key(128'h000102030405060708090a0b0c0d0e0f);
      accept(128'h00112233445566778899aabbccddeeff);
      wait_done(n);
      checks++; if (n != 11 || data_out !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin
         errors++; $display("FAIL fips_c1: got %h (lat %0d) want 69c4e0d86a7b0430d8cdb78070b4c55a", data_out, n);
      end
      release_out();
      for (int i = 0; i < 3; i++) begin
         pt = rand128(); key = rand128(); exp = aes_encrypt(pt, key);
         set_key(key);
         accept(pt);
         wait_done(n);
         checks++; if (out_valid !== 1'b1 || data_out !== exp) begin
            errors++; $display("FAIL aes_random: got %h want %h", data_out, exp);
         end
         release_out();
      end
   endtask

   task automatic test_stall();
      int n;
      logic [127:0] d, d2;
      real_mode = 1'b0;
      d = rand128(); d2 = rand128();
      data_in = d; in_valid = 1'b1;
      tick();
      data_in = d2;
      wait_done(n);
      checks++; if (n != 11) begin
         errors++; $display("FAIL stall_latency: got %0d want 11", n);
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++; if (out_valid !== 1'b1 || data_out !== d + 128'd10 || in_ready !== 1'b0) begin
            errors++; $display("FAIL stall_hold: cyc %0d ov=%b data=%h want %h", i, out_valid, data_out, d + 128'd10);
         end
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || state_q !== d + 128'd10) begin
         errors++; $display("FAIL stall_release: rdy=%b ov=%b busy=%b state=%h", in_ready, out_valid, busy, state_q);
      end
      tick();
      in_valid = 1'b0;
      checks++; if (busy !== 1'b1 || round_idx !== 4'd1 || state_q !== d2) begin
         errors++; $display("FAIL stall_next_accept: busy=%b idx=%0d state=%h want %h", busy, round_idx, state_q, d2);
      end
      wait_done(n);
      checks++; if (data_out !== d2 + 128'd10) begin
         errors++; $display("FAIL stall_second: got %h want %h", data_out, d2 + 128'd10);
      end
      release_out();
   endtask

   task automatic test_reset_mid();
      int n;
      logic [127:0] pt, key;
      real_mode = 1'b1;
      key = rand128(); set_key(key);
      accept(rand128());
      n = 0;
      while (round_idx !== 4'd5 && n < 20) begin
         tick();
         n++;
      end
      checks++; if (round_idx !== 4'd5) begin
         errors++; $display("FAIL reset_mid_reach: got idx=%0d want 5", round_idx);
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checks++; if ({in_ready, busy, out_valid} !== 3'b100 || state_q !== 128'd0 || round_idx !== 4'd0) begin
         errors++; $display("FAIL reset_mid: flags=%b state=%h idx=%0d", {in_ready, busy, out_valid}, state_q, round_idx);
      end
      tick();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_mid_idle: ov=%b rdy=%b", out_valid, in_ready);
      end
      pt = rand128();
      accept(pt);
      wait_done(n);
      checks++; if (out_valid !== 1'b1 || data_out !== aes_encrypt(pt, key)) begin
         errors++; $display("FAIL reset_mid_recover: got %h want %h", data_out, aes_encrypt(pt, key));
      end
      release_out();
   endtask

   task automatic test_back_to_back();
      logic [127:0] exp_q[$];
      logic [127:0] d_now, od, e;
      logic         acc, ov;
      int           last_acc, outs;
      real_mode = 1'b0;
      last_acc = -1; outs = 0;
      data_in = rand128(); in_valid = 1'b1; out_ready = 1'b1;
      for (int cyc = 0; cyc < 120 && outs < 5; cyc++) begin
         acc = in_ready; ov = out_valid; od = data_out; d_now = data_in;
         tick();
         if (acc) begin
            exp_q.push_back(d_now + 128'd10);
            if (last_acc >= 0) begin
               checks++; if (cyc - last_acc != 12) begin
                  errors++; $display("FAIL b2b_interval: got %0d want 12", cyc - last_acc);
               end
            end
            last_acc = cyc;
            data_in = rand128();
         end
         if (ov) begin
            outs++;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
            checks++; if (od !== e) begin
               errors++; $display("FAIL b2b_data: block %0d got %h want %h", outs, od, e);
            end
         end
      end
      checks++; if (outs != 5) begin
         errors++; $display("FAIL b2b_count: got %0d outputs want 5", outs);
      end
      in_valid = 1'b0;
      for (int i = 0; i < 30 && !(in_ready === 1'b1); i++) tick();
      out_ready = 1'b0;
   endtask

   task automatic test_nr12();
      int n;
      logic [127:0] d;
      d = rand128();
      data_in_b = d; in_valid_b = 1'b1;
      tick();
      in_valid_b = 1'b0;
      n = 1;
      while (out_valid_b !== 1'b1 && n < 60) begin
         tick();
         n++;
      end
      checks++; if (n != 13) begin
         errors++; $display("FAIL nr12_latency: got %0d want 13", n);
      end
      checks++; if (data_out_b !== d + 128'd12 || round_idx_b !== 4'd12 || last_round_b !== 1'b1) begin
         errors++; $display("FAIL nr12_data: got %h idx=%0d want %h idx=12", data_out_b, round_idx_b, d + 128'd12);
      end
      out_ready_b = 1'b1;
      tick();
      out_ready_b = 1'b0;
      checks++; if (in_ready_b !== 1'b1 || round_idx_b !== 4'd0) begin
         errors++; $display("FAIL nr12_release: rdy=%b idx=%0d", in_ready_b, round_idx_b);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_valid_b = 1'b0; out_ready_b = 1'b0;
      real_mode = 1'b0; data_in = '0; data_in_b = '0;
      init_sbox();
      test_reset();
      test_stub_latency();
      test_fips();
      test_stall();
      test_reset_mid();
      test_back_to_back();
      test_nr12();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule : tb_aes_round_ctrl

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Iterative AES-128 encryption round sequencer and state register; sits directly downstream of the 128-bit 2:1 datapath select stage.
- Drives that stage's select and registers its output every cycle.
- Combinational round logic (SubBytes/ShiftRows/MixColumns/AddRoundKey) is external. It reads state_q, round_idx and last_round, and returns its result on the select stage's feedback input.
- Provides a valid/ready handshake on block input and output.

Parameters:
NR, 10, number of rounds after initial AddRoundKey (AES-128 = 10)
DW, 128, block width in bits
RW, 4, round index width; must satisfy 2**RW > NR

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, synchronous, active-low
in_valid  input  1  new block is present at the select stage's fresh-block input
in_ready  output  1  block can accept a new input
mux_sel  output  1  select for the upstream 2:1 stage: 1 = fresh block (initial AddRoundKey result), 0 = round feedback
mux_out  input  DW  output of the upstream 2:1 stage
state_q  output  DW  registered AES state, feeds the external round logic
round_idx  output  RW  current round number, also used as the key-schedule round index
last_round  output  1  high when round_idx == NR (round logic skips MixColumns)
busy  output  1  FSM is in RUN
out_valid  output  1  data_out holds the ciphertext
out_ready  input  1  downstream accepts data_out
data_out  output  DW  ciphertext, equal to state_q while out_valid is high

Behaviour:
- Reset (rst_n low at a clock edge): FSM goes to IDLE; state_q = 0, round_idx = 0, out_valid = 0, busy = 0.
- Reset asserted mid-operation aborts the block with no output; rst_n has priority over every other input.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1, mux_sel = 1.
  - On an edge with in_valid = 1: state_q <= mux_out, round_idx <= 1, go to RUN.
  - Otherwise hold; state_q keeps its old value.
- RUN:
  - in_ready = 0, mux_sel = 0, busy = 1.
  - Every edge: state_q <= mux_out.
  - If round_idx == NR: go to DONE, round_idx unchanged. Otherwise round_idx <= round_idx + 1.
  - in_valid is ignored.
- DONE:
  - out_valid = 1, data_out = state_q, in_ready = 0, mux_sel = 0.
  - state_q is held (no load).
  - On an edge with out_ready = 1: go to IDLE, round_idx <= 0.
  - With out_ready held low, stall indefinitely with data_out stable.
- last_round = (round_idx == NR); combinational from the register.
- mux_sel, in_ready, busy and out_valid are decoded combinationally from the state register only. No path from in_valid or out_ready to any output.
- Latency: accept on edge E0, rounds 1..NR on edges E1..E_NR, out_valid high in the cycle after E_NR. That is NR+1 cycles from accept to out_valid (11 for AES-128).
- Throughput: one block per NR+2 cycles when out_ready is held high. The IDLE cycle after DONE is mandatory; no back-to-back accept from DONE.
- in_valid and out_ready in the same DONE cycle: only the output handshake completes. The input is accepted on the following IDLE cycle if in_valid is still high.
- round_idx never exceeds NR and never wraps.
- Illegal or unused state encodings recover to IDLE.

Decomposition:
- Shared package aes_pkg holds:
  - AES_BLK_W = 128
  - AES128_NR = 10
  - round-index width constant
  - FSM state enum {IDLE, RUN, DONE}
- Optional sub-module aes_round_cnt: loadable saturating counter with clear, load-to-1, increment and terminal-count flag. Everything else stays in aes_round_ctrl.

Test Plan:
1. Stub round logic (feedback = state_q + 1). Accept data_in 0x0 -> out_valid exactly 11 cycles after accept, data_out = 0x0A; round_idx sequence 1,2,...,10; last_round high only while round_idx = 10.
2. Real round logic, FIPS-197 C.1: plaintext 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f -> data_out = 69c4e0d86a7b0430d8cdb78070b4c55a.
3. out_ready held low for 5 cycles in DONE -> out_valid stays 1 and data_out is stable. Release -> IDLE next cycle with in_ready = 1; in_valid pulses during RUN and DONE are ignored.
4. rst_n driven low at round 5 -> next cycle: IDLE, state_q = 0, round_idx = 0, out_valid = 0, in_ready = 1. A new block then completes with correct ciphertext.
5. in_valid and out_ready held high continuously with stub logic -> accepts every 12 cycles, data_out = data_in + 10 for each block, no dropped or duplicated blocks.
6. NR = 12 build with stub logic -> out_valid 13 cycles after accept, data_out = data_in + 12.
